// File: rtl/tdr_guarded_param_ctrl.sv
// IJTAG test data register with a negedge shadow, shift-length guard on update,
// self-clearing pulse bits and a low-transparent retiming latch on scan out.
module tdr_guarded_param_ctrl #(
  parameter int               WIDTH        = 20,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter logic [WIDTH-1:0] CAPTURE_MASK = '0,
  parameter logic [WIDTH-1:0] PULSE_MASK   = '0,
  parameter int               PULSE_LEN    = 4,
  parameter int               LENGTH_CHECK = 1
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  input  logic [WIDTH-1:0] status_in,
  output logic [WIDTH-1:0] data_out,
  output logic             ijtag_so,
  output logic             length_err
);

  localparam int             CW       = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_SAT  = CW'(WIDTH + 1);
  localparam logic [7:0]     PLEN     = 8'(PULSE_LEN);

  logic [WIDTH-1:0] tdr, shadow, cap_val, shift_val;
  logic [CW-1:0]    shift_cnt;
  logic [7:0]       pulse_cnt;
  logic             err_q, so_l;
  logic             upd_req, upd_ok, pulse_hit;

  assign cap_val   = (CAPTURE_MASK & status_in) | (~CAPTURE_MASK & shadow);
  assign upd_req   = ijtag_ue & ijtag_sel;
  assign upd_ok    = upd_req & ((LENGTH_CHECK == 0) || (shift_cnt == CNT_FULL));
  assign pulse_hit = |(tdr & PULSE_MASK);

  generate
    if (WIDTH == 1) begin : g_shift1
      assign shift_val = ijtag_si;
    end else begin : g_shiftn
      assign shift_val = {ijtag_si, tdr[WIDTH-1:1]};
    end
  endgenerate

  // Capture wins over shift; the counter saturates so over-shifting never aliases to WIDTH.
  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      tdr       <= '0;
      shift_cnt <= '0;
    end else if (ijtag_sel && ijtag_ce) begin
      tdr       <= cap_val;
      shift_cnt <= '0;
    end else if (ijtag_sel && ijtag_se) begin
      tdr <= shift_val;
      if (shift_cnt != CNT_SAT) shift_cnt <= shift_cnt + CW'(1);
    end
  end

  // An accepted update restarts the pulse timer; otherwise it runs down regardless of sel.
  always_ff @(negedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      shadow    <= RESET_VALUE;
      err_q     <= 1'b0;
      pulse_cnt <= '0;
    end else if (upd_ok) begin
      shadow    <= tdr;
      err_q     <= 1'b0;
      pulse_cnt <= pulse_hit ? PLEN : 8'd0;
    end else begin
      if (upd_req) err_q <= 1'b1;
      if (pulse_cnt > 8'd1) begin
        pulse_cnt <= pulse_cnt - 8'd1;
      end else if (pulse_cnt == 8'd1) begin
        shadow    <= shadow & ~PULSE_MASK;
        pulse_cnt <= '0;
      end
    end
  end

  always_latch begin
    if (ijtag_reset)     so_l <= 1'b0;
    else if (!ijtag_tck) so_l <= tdr[0];
  end

  assign data_out   = shadow;
  assign length_err = err_q;
  assign ijtag_so   = so_l;

endmodule

// File: tb/tb_tdr_guarded_param_ctrl.sv
// Directed bench: reset, guarded updates, capture mask, pulse bits, ce/se priority, sel gating.
module tb_tdr_guarded_param_ctrl;

  logic        ijtag_tck = 1'b0, ijtag_reset = 1'b0, ijtag_sel = 1'b0;
  logic        ijtag_ce = 1'b0, ijtag_se = 1'b0, ijtag_ue = 1'b0, ijtag_si = 1'b0;
  logic [19:0] status_in = '0;
  logic [19:0] data_out;
  logic        ijtag_so, length_err;

  int checks = 0;
  int errors = 0;
  logic [19:0] strm;

  tdr_guarded_param_ctrl #(
    .WIDTH(20), .RESET_VALUE(20'h00005), .CAPTURE_MASK(20'hF0000),
    .PULSE_MASK(20'h00001), .PULSE_LEN(3), .LENGTH_CHECK(1)
  ) dut (
    .ijtag_tck(ijtag_tck), .ijtag_reset(ijtag_reset), .ijtag_sel(ijtag_sel),
    .ijtag_ce(ijtag_ce), .ijtag_se(ijtag_se), .ijtag_ue(ijtag_ue), .ijtag_si(ijtag_si),
    .status_in(status_in), .data_out(data_out), .ijtag_so(ijtag_so), .length_err(length_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One tck period; returns 2 time units after the falling edge (tck low).
  task automatic cyc();
    #3 ijtag_tck = 1'b1;
    #5 ijtag_tck = 1'b0;
    #2;
  endtask

  task automatic step(input logic c, input logic s, input logic u, input logic d);
    ijtag_ce = c; ijtag_se = s; ijtag_ue = u; ijtag_si = d;
    cyc();
    ijtag_ce = 1'b0; ijtag_se = 1'b0; ijtag_ue = 1'b0; ijtag_si = 1'b0;
  endtask

  // Capture then n shifts of val LSB-first; stream collects what appears on ijtag_so.
  task automatic scan(input logic [19:0] val, input int n, output logic [19:0] stream);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    stream = '0;
    for (int i = 0; i < n; i++) begin
      stream[i] = ijtag_so;
      step(1'b0, 1'b1, 1'b0, val[i]);
    end
  endtask

  task automatic load(input logic [19:0] val, input int n, output logic [19:0] stream);
    scan(val, n, stream);
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    // reset with the clock stopped
    #2 ijtag_reset = 1'b1;
    #3;
    check("rst_data", 32'(data_out), 32'h00005);
    check("rst_err",  32'(length_err), 32'h0);
    check("rst_so",   32'(ijtag_so), 32'h0);
    ijtag_reset = 1'b0;
    #5 ijtag_sel = 1'b1;

    // full-length load; old shadow streams out
    load(20'hABCDE, 20, strm);
    check("load1_stream", 32'(strm), 32'h00005);
    check("load1_data",   32'(data_out), 32'hABCDE);
    check("load1_err",    32'(length_err), 32'h0);

    // short shift is rejected; flag is sticky and re-evaluated on repeat update
    load(20'h12345, 19, strm);
    check("short_data", 32'(data_out), 32'hABCDE);
    check("short_err",  32'(length_err), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("reupd_data", 32'(data_out), 32'hABCDE);
    check("reupd_err",  32'(length_err), 32'h1);
    cyc();
    check("err_hold",   32'(length_err), 32'h1);
    load(20'h01234, 20, strm);
    check("recov_stream", 32'(strm), 32'h0BCDE);
    check("recov_data",   32'(data_out), 32'h01234);
    check("recov_err",    32'(length_err), 32'h0);

    // capture mask mixes status_in into the upper nibble
    status_in = 20'h3FFFF;
    scan(20'h01234, 20, strm);
    check("capmask_stream", 32'(strm), 32'h31234);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("capmask_data", 32'(data_out), 32'h01234);

    // pulse bit lasts exactly 3 periods, static bit 10 stays
    load(20'h00401, 20, strm);
    check("pulse_t0", 32'(data_out), 32'h00401);
    cyc(); check("pulse_t1", 32'(data_out), 32'h00401);
    cyc(); check("pulse_t2", 32'(data_out), 32'h00401);
    cyc(); check("pulse_t3", 32'(data_out), 32'h00400);
    cyc(); check("pulse_t4", 32'(data_out), 32'h00400);

    // update during the pulse restarts the count
    load(20'h00401, 20, strm);
    cyc(); check("rst_pulse_t1", 32'(data_out), 32'h00401);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("restart_t0", 32'(data_out), 32'h00401);
    cyc(); check("restart_t1", 32'(data_out), 32'h00401);
    cyc(); check("restart_t2", 32'(data_out), 32'h00401);
    cyc(); check("restart_t3", 32'(data_out), 32'h00400);

    // ce and se together: capture only
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("cese_so", 32'(ijtag_so), 32'h0);
    strm = '0;
    for (int i = 0; i < 20; i++) begin
      strm[i] = ijtag_so;
      step(1'b0, 1'b1, 1'b0, (i >= 16 && i <= 17) || i == 10);
    end
    check("cese_stream", 32'(strm), 32'h30400);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("cese_data", 32'(data_out), 32'h30400);
    check("cese_err",  32'(length_err), 32'h0);

    // deselected: capture/shift/update ignored
    status_in = 20'h00000;
    scan(20'h00002, 20, strm);
    ijtag_sel = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("nosel_upd_data", 32'(data_out), 32'h30400);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("nosel_data", 32'(data_out), 32'h30400);
    check("nosel_err",  32'(length_err), 32'h0);
    check("nosel_so",   32'(ijtag_so), 32'h0);
    ijtag_sel = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("resel_data", 32'(data_out), 32'h00002);
    check("resel_err",  32'(length_err), 32'h0);

    // reset in the middle of a pulse
    load(20'h00401, 20, strm);
    cyc();
    check("midpulse_data", 32'(data_out), 32'h00401);
    ijtag_reset = 1'b1;
    #1;
    check("midrst_data", 32'(data_out), 32'h00005);
    check("midrst_err",  32'(length_err), 32'h0);
    check("midrst_so",   32'(ijtag_so), 32'h0);
    ijtag_reset = 1'b0;
    #1;
    cyc(); cyc(); cyc();
    check("postrst_data", 32'(data_out), 32'h00005);
    load(20'hABCDE, 20, strm);
    check("postrst_stream", 32'(strm), 32'h00005);
    check("postrst_load",   32'(data_out), 32'hABCDE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
